// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first.
// Ports: clk, rst (sync, active-high), start/a/b/sub in; busy, done, sum, cout, overflow out.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sha_q, sha_d;
   logic [WIDTH-1:0] shb_q, shb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             s;
   logic             cnew;
   logic             last;

   assign s    = sha_q[0] ^ shb_q[0] ^ carry_q;
   assign cnew = (sha_q[0] & shb_q[0]) | (sha_q[0] & carry_q) |
                 (shb_q[0] & carry_q);
   assign last = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      state_d = state_q;
      sha_d   = sha_q;
      shb_d   = shb_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               sha_d   = a;
               // Subtraction is A + ~B + 1: invert B, seed carry with 1.
               shb_d   = sub ? ~b : b;
               carry_d = sub;
               cnt_d   = '0;
               acc_d   = '0;
            end
         end
         RUN: begin
            sha_d          = sha_q >> 1;
            shb_d          = shb_q >> 1;
            carry_d        = cnew;
            acc_d          = acc_q >> 1;
            acc_d[WIDTH-1] = s;
            cnt_d          = cnt_q + CW'(1);
            if (last) begin
               sum_d   = acc_d;
               cout_d  = cnew;
               // carry_q is the carry into the MSB here.
               ovf_d   = carry_q ^ cnew;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sha_q   <= '0;
         shb_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sha_q   <= sha_d;
         shb_q   <= shb_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule
